alu_result_framer: RTL and testbench
====================================

Name: alu_result_framer

Overview:
- Consumer end of the ALU result interface: captures each registered ALU result word on its valid strobe and buffers it in a small FIFO.
- Serialises each buffered word into bytes, least significant byte first, for the UART TX byte interface.
- Sits between the ALU and the UART TX parallel input, so ALU results never stall or wait on the serial link.

Parameters:
- RES_WIDTH, 16, ALU result word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of the TX parallel byte.
- FIFO_DEPTH, 4, result-word buffer depth; must be a power of two, minimum 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- RES_IN  in  RES_WIDTH  ALU result word.
- RES_VALID  in  1  one-cycle strobe; RES_IN is valid this cycle.
- TX_BUSY  in  1  UART TX busy flag; high from byte acceptance until its frame completes.
- TX_P_DATA  out  BYTE_WIDTH  byte presented to UART TX.
- TX_D_VLD  out  1  one-cycle byte-valid pulse.
- FIFO_FULL  out  1  buffer holds FIFO_DEPTH words.
- DROP  out  1  one-cycle pulse when a result is discarded because the buffer is full.
- FRAMER_BUSY  out  1  high while the FIFO is non-empty or the FSM is not in IDLE.

Behaviour:
- Reset (async, RST=1):
  - All outputs go to 0, FIFO pointers and count clear, FSM enters IDLE, shift register and byte counter clear.
  - Reset mid-frame abandons the word and all buffered words. No partial byte is emitted after RST deasserts.
- Push:
  - When RES_VALID=1 and the registered count is less than FIFO_DEPTH, RES_IN is written at the write pointer; the pointer wraps modulo FIFO_DEPTH.
  - When RES_VALID=1 and the buffer is full, the word is discarded and DROP=1 in the following cycle. FIFO contents are unchanged.
- Full detection:
  - Fullness is evaluated on the registered count only.
  - A push in the same cycle as a pop while full is still dropped.
- Simultaneous push and pop while not full: both occur and the count is unchanged.
- FIFO_FULL is registered and equals (count == FIFO_DEPTH).
- NB = RES_WIDTH/BYTE_WIDTH (2 by default).
- FSM states:
  - IDLE: if count > 0, pop the head word into the shift register, clear the byte counter, go to SEND. The pop happens this cycle.
  - SEND: if TX_BUSY=0, register TX_P_DATA = shift[BYTE_WIDTH-1:0], pulse TX_D_VLD=1 for exactly one cycle, go to WAIT_HI. If TX_BUSY=1, hold in SEND with TX_D_VLD=0.
  - WAIT_HI: wait for TX_BUSY=1 (TX accepted), then go to WAIT_LO. TX_D_VLD=0.
  - WAIT_LO: wait for TX_BUSY=0. On that cycle:
    - shift right by BYTE_WIDTH and increment the byte counter;
    - if the byte counter was NB-1, go to IDLE;
    - otherwise go to SEND.
- TX_P_DATA holds its last value between pulses and is not cleared by FSM transitions.
- Latency:
  - Empty buffer, idle TX: RES_VALID at edge k gives the FIFO write at k and the pop in IDLE at k+1. TX_D_VLD is high in the cycle after edge k+2.
  - Subsequent bytes: one cycle after TX_BUSY falls, provided TX_BUSY stays low in SEND.
- Back-to-back words: IDLE pops the next word immediately, with no idle gap beyond the one IDLE cycle.
- Byte order: LSB first. Words leave in arrival order.

Test Plan:
- Single word, TX model busy for 10 cycles per byte: RES_IN=0xBEEF, one RES_VALID pulse -> TX_D_VLD pulses twice, TX_P_DATA 0xEF then 0xBE, FRAMER_BUSY returns to 0, DROP never asserted.
- Burst of 5 words (0x0001..0x0005) on consecutive cycles while TX_BUSY is held high:
  - 0x0001 is popped into the shift register, and 0x0002..0x0005 are written, so FIFO_FULL=1 and no DROP occurs.
  - A 6th word 0x0006 arrives -> DROP pulses once and FIFO_FULL stays 1.
  - On release, the bytes received are 01,00,02,00,...,05,00 and 0x0006 never appears.
- Pointer wrap: 12 words sent with the TX model always ready -> all 24 bytes arrive in order, and the pointers wrap three times without loss.
- Simultaneous push/pop at count=3 in IDLE -> count remains 3 and order is preserved. Push on a full buffer in the pop cycle -> DROP=1.
- RST asserted in WAIT_LO after the first byte of 0x1234 (0x34 sent) with 2 words queued -> outputs 0 immediately. After release, no 0x12 byte is emitted and FRAMER_BUSY=0.
- TX_BUSY stuck high for 200 cycles in SEND -> TX_D_VLD stays 0 throughout. After TX_BUSY falls, exactly one pulse follows.

Source files
------------

// File: rtl/alu_result_framer.sv
// alu_result_framer: buffers ALU result words in a small FIFO and
// serialises each word LSB-first onto the UART TX byte interface.
module alu_result_framer #(
  parameter int RES_WIDTH  = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [RES_WIDTH-1:0]  RES_IN,
  input  logic                  RES_VALID,
  input  logic                  TX_BUSY,
  output logic [BYTE_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  FIFO_FULL,
  output logic                  DROP,
  output logic                  FRAMER_BUSY
);
  localparam int NB  = RES_WIDTH / BYTE_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [BCW-1:0] LAST_B  = BCW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_HI, WAIT_LO
  } state_t;

  logic [RES_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  state_t                state_q;
  logic [RES_WIDTH-1:0]  shift_q;
  logic [BCW-1:0]        bcnt_q;
  logic [BYTE_WIDTH-1:0] tx_data_q;
  logic                  tx_vld_q;
  logic                  full_q;
  logic                  drop_q;
  logic                  full_c;
  logic                  push;
  logic                  pop;

  // Fullness uses the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  always_comb begin
    full_c   = (count_q == DEPTH_C);
    push     = RES_VALID && !full_c;
    pop      = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= RES_IN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      drop_q   <= RES_VALID && full_c;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcnt_q    <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
    end else begin
      tx_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            bcnt_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (!TX_BUSY) begin
            tx_data_q <= shift_q[BYTE_WIDTH-1:0];
            tx_vld_q  <= 1'b1;
            state_q   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (TX_BUSY) state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!TX_BUSY) begin
            shift_q <= shift_q >> BYTE_WIDTH;
            bcnt_q  <= bcnt_q + 1'b1;
            state_q <= (bcnt_q == LAST_B) ? IDLE : SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign FIFO_FULL   = full_q;
  assign DROP        = drop_q;
  assign FRAMER_BUSY = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_result_framer.sv
// tb_alu_result_framer: random and directed stimulus against a
// queue-based model of the result framer and a UART TX model.
module tb_alu_result_framer;
  localparam int RW = 16;
  localparam int BW = 8;
  localparam int D  = 4;
  localparam int NB = RW / BW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [RW-1:0] res_in = '0;
  logic          res_valid = 1'b0;
  logic          tx_busy;
  logic [BW-1:0] tx_p_data;
  logic          tx_d_vld;
  logic          fifo_full;
  logic          drop;
  logic          framer_busy;

  logic          tx_hold = 1'b0;
  int            tx_cnt = 0;
  int            busy_len = 10;
  bit            rand_busy = 0;

  assign tx_busy = (tx_cnt != 0) || tx_hold;

  alu_result_framer #(
    .RES_WIDTH (RW),
    .BYTE_WIDTH(BW),
    .FIFO_DEPTH(D)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RES_IN     (res_in),
    .RES_VALID  (res_valid),
    .TX_BUSY    (tx_busy),
    .TX_P_DATA  (tx_p_data),
    .TX_D_VLD   (tx_d_vld),
    .FIFO_FULL  (fifo_full),
    .DROP       (drop),
    .FRAMER_BUSY(framer_busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state: words buffered, bytes still owed, framer occupancy
  logic [RW-1:0] mq[$];
  logic [BW-1:0] exp_bytes[$];
  logic [BW-1:0] rx_log[$];
  int            vcyc[$];
  bit            holding = 0;
  bit            seen_hi = 0;
  bit            exp_drop = 0;
  bit            m_full;
  logic [RW-1:0] m_w;
  int            lasts_acc = 0;
  int            lasts_done = 0;
  int            bytes_rx = 0;
  int            vld_cnt = 0;
  int            drop_cnt = 0;
  int            cyc = 0;
  bit            prev_busy;

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      mq.delete();
      exp_bytes.delete();
      holding = 0;
      seen_hi = 0;
      exp_drop = 0;
      lasts_done = 0;
    end else begin
      m_full = (mq.size() == D);
      exp_drop = res_valid && m_full;
      if (!holding && mq.size() > 0) begin
        m_w = mq.pop_front();
        holding = 1;
        for (int i = 0; i < NB; i++)
          exp_bytes.push_back(m_w[i*BW +: BW]);
      end else if (holding && lasts_acc != lasts_done) begin
        if (seen_hi && !tx_busy) begin
          holding = 0;
          seen_hi = 0;
          lasts_done++;
        end else if (tx_busy) begin
          seen_hi = 1;
        end
      end
      if (res_valid && !m_full) mq.push_back(res_in);
    end
  end

  // UART TX model and per-cycle output checks
  always begin
    @(negedge CLK);
    #1;
    if (RST) begin
      tx_cnt = 0;
      bytes_rx = 0;
      lasts_acc = 0;
    end else begin
      prev_busy = tx_busy;
      if (tx_cnt > 0) tx_cnt--;
      if (tx_d_vld) begin
        vld_cnt++;
        rx_log.push_back(tx_p_data);
        vcyc.push_back(cyc);
        check("vld_while_busy", prev_busy, 0);
        check("byte_owed", exp_bytes.size() > 0, 1);
        if (exp_bytes.size() > 0)
          check("byte", tx_p_data, exp_bytes.pop_front());
        tx_cnt = rand_busy ? $urandom_range(1, 4) : busy_len;
        bytes_rx++;
        if (bytes_rx % NB == 0) lasts_acc++;
      end
      if (drop) drop_cnt++;
      check("drop", drop, exp_drop);
      check("full", fifo_full, mq.size() == D);
      check("fbusy", framer_busy, (mq.size() > 0) || holding);
    end
  end

  task automatic push_word(input logic [RW-1:0] w);
    @(negedge CLK);
    res_in = w;
    res_valid = 1'b1;
    @(negedge CLK);
    res_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_idle(input int bound);
    bit idle;
    idle = 0;
    for (int i = 0; i < bound && !idle; i++) begin
      @(negedge CLK);
      #2;
      idle = !framer_busy && !tx_busy && !tx_d_vld;
    end
    check("idle_timeout", idle, 1);
  endtask

  int v0, d0, t0;
  logic [RW-1:0] words[$];

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    check("rst_data", tx_p_data, 0);
    check("rst_vld", tx_d_vld, 0);
    check("rst_full", fifo_full, 0);
    check("rst_drop", drop, 0);
    check("rst_fbusy", framer_busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    idle_cycles(2);

    // single word with 10-cycle TX frames
    rx_log.delete();
    vcyc.delete();
    v0 = vld_cnt;
    d0 = drop_cnt;
    @(negedge CLK);
    t0 = cyc;
    res_in = 16'hBEEF;
    res_valid = 1'b1;
    @(negedge CLK);
    res_valid = 1'b0;
    wait_idle(200);
    check("t1_nbytes", vld_cnt - v0, 2);
    check("t1_b0", rx_log[0], 8'hEF);
    check("t1_b1", rx_log[1], 8'hBE);
    check("t1_lat", vcyc[0] - t0, 3);
    check("t1_gap", vcyc[1] - vcyc[0], busy_len + 2);
    check("t1_drops", drop_cnt - d0, 0);
    check("t1_fbusy", framer_busy, 0);

    // burst of six with TX held busy
    rx_log.delete();
    d0 = drop_cnt;
    v0 = vld_cnt;
    @(negedge CLK);
    tx_hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      res_in = RW'(i);
      res_valid = 1'b1;
    end
    @(negedge CLK);
    res_in = 16'h0006;
    #2;
    check("t2_nodrop5", drop_cnt - d0, 0);
    check("t2_full5", fifo_full, 1);
    @(negedge CLK);
    res_valid = 1'b0;
    #2;
    check("t2_drop6", drop_cnt - d0, 1);
    idle_cycles(3);
    #2;
    check("t2_full6", fifo_full, 1);
    check("t2_drops", drop_cnt - d0, 1);
    check("t2_novld", vld_cnt - v0, 0);
    @(negedge CLK);
    tx_hold = 1'b0;
    wait_idle(400);
    check("t2_nbytes", rx_log.size(), 10);
    for (int i = 0; i < 10 && i < rx_log.size(); i++)
      check("t2_byte", rx_log[i], (i % 2 == 0) ? i / 2 + 1 : 0);

    // pointer wrap with a fast TX
    busy_len = 1;
    rx_log.delete();
    words.delete();
    d0 = drop_cnt;
    for (int i = 0; i < 12; i++) begin
      words.push_back(RW'($urandom));
      push_word(words[i]);
      idle_cycles(7);
    end
    wait_idle(200);
    check("t3_nbytes", rx_log.size(), 24);
    check("t3_drops", drop_cnt - d0, 0);
    for (int i = 0; i < 24 && i < rx_log.size(); i++)
      check("t3_byte", rx_log[i], words[i/2][(i%2)*BW +: BW]);

    // random traffic and TX latency
    rand_busy = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      res_in = RW'($urandom);
      res_valid = ($urandom_range(0, 2) == 0);
    end
    @(negedge CLK);
    res_valid = 1'b0;
    wait_idle(400);
    check("t4_owed", exp_bytes.size(), 0);
    check("t4_fbusy", framer_busy, 0);
    rand_busy = 0;

    // reset mid-frame after the first byte
    busy_len = 10;
    rx_log.delete();
    v0 = vld_cnt;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      res_in = (i == 0) ? 16'h1234 : RW'($urandom);
      res_valid = 1'b1;
      @(negedge CLK);
    end
    res_valid = 1'b0;
    for (int i = 0; i < 20 && vld_cnt == v0; i++) begin
      @(negedge CLK);
      #2;
    end
    check("t5_first", vld_cnt - v0, 1);
    check("t5_b0", rx_log.size() > 0 ? rx_log[0] : 8'h00, 8'h34);
    idle_cycles(3);
    RST = 1'b1;
    #1;
    check("t5_data0", tx_p_data, 0);
    check("t5_vld0", tx_d_vld, 0);
    check("t5_full0", fifo_full, 0);
    check("t5_drop0", drop, 0);
    check("t5_fbusy0", framer_busy, 0);
    idle_cycles(2);
    RST = 1'b0;
    v0 = vld_cnt;
    idle_cycles(40);
    #2;
    check("t5_nobytes", vld_cnt - v0, 0);
    check("t5_fbusy", framer_busy, 0);

    // TX stuck busy in SEND
    rx_log.delete();
    @(negedge CLK);
    tx_hold = 1'b1;
    v0 = vld_cnt;
    push_word(16'hC3A5);
    idle_cycles(200);
    #2;
    check("t6_stuck", vld_cnt - v0, 0);
    check("t6_fbusy", framer_busy, 1);
    @(negedge CLK);
    tx_hold = 1'b0;
    idle_cycles(5);
    #2;
    check("t6_one", vld_cnt - v0, 1);
    check("t6_b0", rx_log.size() > 0 ? rx_log[0] : 8'h00, 8'hA5);
    wait_idle(200);
    check("t6_total", vld_cnt - v0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
